// File: rtl/instruction_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Purpose  : Front-end fetch stage. Issues one outstanding 32-bit fetch at a
//             time, makes a static branch prediction on each returned word,
//             and buffers fetched instructions in a small in-order queue that
//             feeds decode one entry per cycle.
//  Ports    : clk, rst (async, active-high)
//             in_stall             - decode cannot accept this cycle
//             in_flush/in_flush_pc - misprediction restart (highest priority)
//             out_mem_req/out_mem_addr  - fetch request to memory controller
//             in_mem_valid/in_mem_inst  - fetch response (one-cycle pulse)
//             out_decode_ena       - head entry handed to decode (popped)
//             out_inst/out_pc/out_predicted_taken - head entry contents
//  Params   : QUEUE_DEPTH - queue entries, power of two, >= 2
//  Macros   : FETCH_BTFN_PREDICT_EN - predict backward conditional branches
//             taken (BTFN); when undefined all conditional branches are
//             predicted not taken. JAL is predicted taken in both builds.
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_stall,
    input  logic        in_flush,
    input  logic [31:0] in_flush_pc,
    output logic        out_mem_req,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_valid,
    input  logic [31:0] in_mem_inst,
    output logic        out_decode_ena,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic        out_predicted_taken
);

    localparam int              c_PW    = $clog2(QUEUE_DEPTH);
    localparam int              c_CW    = c_PW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t          r_state, w_state_next;
    logic [31:0]     r_fetch_pc, w_fetch_pc_next;

    logic [31:0]     r_q_inst [QUEUE_DEPTH];
    logic [31:0]     r_q_pc   [QUEUE_DEPTH];
    logic            r_q_pred [QUEUE_DEPTH];
    logic [c_PW-1:0] r_head, r_tail, w_head_adv;
    logic [c_CW-1:0] r_count, w_count_next;

    logic [31:0]     r_out_inst, r_out_pc;
    logic            r_out_pred;
    logic [31:0]     w_nh_inst, w_nh_pc;
    logic            w_nh_pred;

    logic            w_push, w_pop;
    logic            w_pred;
    logic [31:0]     w_next_pc;
    logic [6:0]      w_opcode;
    logic [31:0]     w_j_imm;

    // ------------------------------------------------------------------
    // Static prediction on the returned word (PC of the word is fetch_pc)
    // ------------------------------------------------------------------
    assign w_opcode = in_mem_inst[6:0];
    assign w_j_imm  = {{11{in_mem_inst[31]}}, in_mem_inst[31], in_mem_inst[19:12],
                       in_mem_inst[20], in_mem_inst[30:21], 1'b0};

`ifdef FETCH_BTFN_PREDICT_EN
    logic [31:0] w_b_imm;
    assign w_b_imm = {{19{in_mem_inst[31]}}, in_mem_inst[31], in_mem_inst[7],
                      in_mem_inst[30:25], in_mem_inst[11:8], 1'b0};
`else
    // rd / B-immediate low bits are not needed without BTFN prediction
    logic w_unused_rd_bits;
    assign w_unused_rd_bits = ^in_mem_inst[11:7];
`endif

    always_comb begin
        w_pred    = 1'b0;
        w_next_pc = r_fetch_pc + 32'd4;
        if (w_opcode == 7'b1101111) begin
            w_pred    = 1'b1;
            w_next_pc = r_fetch_pc + w_j_imm;
        end
`ifdef FETCH_BTFN_PREDICT_EN
        else if ((w_opcode == 7'b1100011) && in_mem_inst[31]) begin
            w_pred    = 1'b1;
            w_next_pc = r_fetch_pc + w_b_imm;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Queue handshakes
    // ------------------------------------------------------------------
    assign w_pop        = (r_count != '0) && !in_stall && !in_flush;
    assign w_push       = (r_state == S_WAIT) && in_mem_valid && !in_flush;
    assign w_count_next = r_count + c_CW'(w_push) - c_CW'(w_pop);

    // Next head entry; when the queue held exactly one entry and it is popped
    // while a word is pushed, the new head is the word being written now.
    always_comb begin
        w_head_adv = w_pop ? (r_head + c_PW'(1)) : r_head;
        if (w_push && (w_head_adv == r_tail)) begin
            w_nh_inst = in_mem_inst;
            w_nh_pc   = r_fetch_pc;
            w_nh_pred = w_pred;
        end else begin
            w_nh_inst = r_q_inst[w_head_adv];
            w_nh_pc   = r_q_pc[w_head_adv];
            w_nh_pred = r_q_pred[w_head_adv];
        end
    end

    // ------------------------------------------------------------------
    // Fetch FSM next-state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        if (in_flush) begin
            w_fetch_pc_next = in_flush_pc;
            case (r_state)
                // an unanswered request must have its stale response dropped
                S_WAIT, S_DISCARD: w_state_next = in_mem_valid ? S_IDLE : S_DISCARD;
                default:           w_state_next = S_IDLE;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count < c_DEPTH)
                        w_state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (in_mem_valid) begin
                        w_fetch_pc_next = w_next_pc;
                        w_state_next    = (w_count_next < c_DEPTH) ? S_WAIT : S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (in_mem_valid)
                        w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_out_inst <= '0;
            r_out_pc   <= '0;
            r_out_pred <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            if (w_push)
                r_tail <= r_tail + c_PW'(1);
            if (in_flush) begin
                r_head  <= r_tail;
                r_count <= '0;
            end else begin
                r_head  <= w_head_adv;
                r_count <= w_count_next;
                // head outputs hold their last value while the queue is empty
                if (w_count_next != '0) begin
                    r_out_inst <= w_nh_inst;
                    r_out_pc   <= w_nh_pc;
                    r_out_pred <= w_nh_pred;
                end
            end
        end
    end

    // Queue storage (no reset needed; only read when valid)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_inst[r_tail] <= in_mem_inst;
            r_q_pc[r_tail]   <= r_fetch_pc;
            r_q_pred[r_tail] <= w_pred;
        end
    end

    assign out_mem_req         = (r_state == S_WAIT);
    assign out_mem_addr        = r_fetch_pc;
    assign out_decode_ena      = w_pop;
    assign out_inst            = r_out_inst;
    assign out_pc              = r_out_pc;
    assign out_predicted_taken = r_out_pred;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch
//  Purpose  : Self-checking bench for instruction_fetch. A memory model
//             answers requests with configurable latency from a table of
//             instruction words that records each word's prediction meaning;
//             a queue-based reference model predicts every output per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    localparam int c_DEPTH = 4;
`ifdef FETCH_BTFN_PREDICT_EN
    localparam logic [31:0] c_BEQ_NEXT = 32'h38;
    localparam logic        c_BEQ_PRED = 1'b1;
`else
    localparam logic [31:0] c_BEQ_NEXT = 32'h44;
    localparam logic        c_BEQ_PRED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_stall, in_flush, in_mem_valid;
    logic [31:0] in_flush_pc, in_mem_inst;
    logic        out_mem_req, out_decode_ena, out_predicted_taken;
    logic [31:0] out_mem_addr, out_inst, out_pc;

    always #5 clk = ~clk;

    instruction_fetch #(.QUEUE_DEPTH(c_DEPTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_stall            (in_stall),
        .in_flush            (in_flush),
        .in_flush_pc         (in_flush_pc),
        .out_mem_req         (out_mem_req),
        .out_mem_addr        (out_mem_addr),
        .in_mem_valid        (in_mem_valid),
        .in_mem_inst         (in_mem_inst),
        .out_decode_ena      (out_decode_ena),
        .out_inst            (out_inst),
        .out_pc              (out_pc),
        .out_predicted_taken (out_predicted_taken)
    );

    typedef struct packed { logic [31:0] inst; logic [31:0] pc; logic pred; } ent_t;
    typedef struct packed { logic [31:0] inst; logic pred; logic [31:0] nxt; } mw_t;

    mw_t         tbl [logic [31:0]];
    int          n_tests = 0;
    int          n_fail  = 0;

    ent_t        m_q[$];
    ent_t        m_last;
    logic [31:0] m_pc;
    logic        m_req, m_disc;

    logic        p_pend;
    logic [31:0] p_addr;
    int          p_cnt;
    int          lat_cfg;
    bit          lat_rand;

    logic [31:0] req_log[$];
    ent_t        dec_log[$];
    int          n_ena;
    logic        obs_ena;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_j(input logic [20:1] o, input logic [4:0] rd);
        return {o[20], o[10:1], o[11], o[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:1] o, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [2:0] f3);
        return {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'b1100011};
    endfunction

    task automatic set_w(input logic [31:0] a, input logic [31:0] inst,
                         input logic pred, input logic [31:0] nxt);
        mw_t w;
        w.inst = inst; w.pred = pred; w.nxt = nxt;
        tbl[a] = w;
    endtask

    // Lazily fill memory with a random mix of ALU, LUI, JALR, JAL and branches
    task automatic ensure(input logic [31:0] a);
        logic [31:0] r, off;
        mw_t         w;
        if (!tbl.exists(a)) begin
            r      = $urandom;
            w.pred = 1'b0;
            w.nxt  = a + 32'd4;
            if (r[3:0] <= 4'd6)      w.inst = {r[31:7], 7'b0010011};
            else if (r[3:0] <= 4'd8) w.inst = {r[31:7], 7'b0110111};
            else if (r[3:0] == 4'd9) w.inst = {r[31:7], 7'b1100111};
            else if (r[3:0] <= 4'd11) begin
                off    = {{11{r[20]}}, r[20:1], 1'b0};
                w.inst = enc_j(off[20:1], r[31:27]);
                w.pred = 1'b1;
                w.nxt  = a + off;
            end else begin
                off    = {{19{r[12]}}, r[12:1], 1'b0};
                w.inst = enc_b(off[12:1], r[31:27], r[26:22], r[15:13]);
`ifdef FETCH_BTFN_PREDICT_EN
                if (off[31]) begin
                    w.pred = 1'b1;
                    w.nxt  = a + off;
                end
`endif
            end
            tbl[a] = w;
        end
    endtask

    // One clock cycle: memory responds, outputs checked, model advanced.
    task automatic step(input logic stall, input logic flush, input logic [31:0] fpc);
        logic mv, exp_ena, room_now;
        ent_t e;
        if (!p_pend && out_mem_req) begin
            p_pend = 1'b1;
            p_addr = out_mem_addr;
            ensure(p_addr);
            p_cnt  = lat_rand ? int'($urandom_range(0, 3)) : lat_cfg;
            req_log.push_back(p_addr);
        end
        mv           = p_pend && (p_cnt == 0);
        in_stall     = stall;
        in_flush     = flush;
        in_flush_pc  = fpc;
        in_mem_valid = mv;
        in_mem_inst  = mv ? tbl[p_addr].inst : $urandom;
        #1;
        exp_ena = (m_q.size() != 0) && !stall && !flush;
        chk("mem_req", out_mem_req, m_req);
        if (m_req) chk("mem_addr", out_mem_addr, m_pc);
        chk("decode_ena", out_decode_ena, exp_ena);
        chk("head_inst", out_inst, m_last.inst);
        chk("head_pc", out_pc, m_last.pc);
        chk("head_pred", out_predicted_taken, m_last.pred);
        obs_ena = out_decode_ena;
        if (out_decode_ena) begin
            n_ena++;
            e.inst = out_inst; e.pc = out_pc; e.pred = out_predicted_taken;
            dec_log.push_back(e);
        end
        // reference model
        room_now = m_q.size() < c_DEPTH;
        if (exp_ena) void'(m_q.pop_front());
        if (flush) begin
            m_q.delete();
            m_pc = fpc;
            if (m_req && !mv)       m_disc = 1'b1;
            else if (m_disc && mv)  m_disc = 1'b0;
            m_req = 1'b0;
        end else if (m_req) begin
            if (mv) begin
                ensure(m_pc);
                e.inst = tbl[m_pc].inst; e.pc = m_pc; e.pred = tbl[m_pc].pred;
                m_q.push_back(e);
                m_pc  = tbl[m_pc].nxt;
                m_req = m_q.size() < c_DEPTH;
            end
        end else if (m_disc) begin
            if (mv) m_disc = 1'b0;
        end else begin
            m_req = room_now;
        end
        if (m_q.size() != 0) m_last = m_q[0];
        if (mv)          p_pend = 1'b0;
        else if (p_pend) p_cnt--;
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [31:0] exp_req [11];
        int          n0;
        int          base;
        bit          ready;

        rst = 1'b1; in_stall = 1'b0; in_flush = 1'b0; in_flush_pc = '0;
        in_mem_valid = 1'b0; in_mem_inst = '0;
        m_q.delete(); m_last = '0; m_pc = '0; m_req = 1'b0; m_disc = 1'b0;
        p_pend = 1'b0; p_addr = '0; p_cnt = 0; lat_cfg = 0; lat_rand = 1'b0;
        n_ena = 0; obs_ena = 1'b0;

        // program: ADDI run, JAL +0x20 at 0x10, BEQ -8 at 0x40, ADDI regions
        for (int a = 0; a < 32'h60; a += 4) set_w(a, 32'h00100093, 1'b0, a + 4);
        set_w(32'h10, enc_j(20'h00010, 5'd1), 1'b1, 32'h30);
        set_w(32'h40, enc_b(12'hFFC, 5'd1, 5'd2, 3'b000), c_BEQ_PRED, c_BEQ_NEXT);
        for (int a = 32'h100; a < 32'h120; a += 4) set_w(a, 32'h00208113, 1'b0, a + 4);
        for (int a = 32'h200; a < 32'h220; a += 4) set_w(a, 32'h00310193, 1'b0, a + 4);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", out_mem_req, 0);
        chk("rst_mem_addr", out_mem_addr, 0);
        chk("rst_decode_ena", out_decode_ena, 0);
        chk("rst_inst", out_inst, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_pred", out_predicted_taken, 0);
        rst = 1'b0;

        // straight-line fetch, JAL redirect, BEQ prediction (latency 0)
        repeat (12) step(1'b0, 1'b0, 32'h0);
        exp_req = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h30, 32'h34,
                    32'h38, 32'h3C, 32'h40, c_BEQ_NEXT};
        chk("d1_req_count_ok", 32'(req_log.size() >= 11), 1);
        chk("d1_dec_count_ok", 32'(dec_log.size() >= 10), 1);
        for (int i = 0; i < 11; i++) chk("d1_req_addr", req_log[i], exp_req[i]);
        for (int i = 0; i < 3; i++) begin
            chk("d1_dec_pc", dec_log[i].pc, 32'(i * 4));
            chk("d1_dec_pred", dec_log[i].pred, 0);
        end
        chk("jal_pc", dec_log[4].pc, 32'h10);
        chk("jal_pred", dec_log[4].pred, 1);
        chk("beq_pc", dec_log[9].pc, 32'h40);
        chk("beq_pred", dec_log[9].pred, c_BEQ_PRED);

        // flush coinciding with a response, then fill queue under stall
        step(1'b0, 1'b1, 32'h200);
        chk("flushv_idle_req", out_mem_req, 0);
        step(1'b1, 1'b0, 32'h0);
        chk("flushv_req", out_mem_req, 1);
        chk("flushv_addr", out_mem_addr, 32'h200);
        repeat (6) step(1'b1, 1'b0, 32'h0);
        chk("full_req_low", out_mem_req, 0);
        chk("full_no_decode", obs_ena, 0);
        n0 = n_ena;
        step(1'b0, 1'b0, 32'h0);
        chk("full_req_after_pop", out_mem_req, 0);
        step(1'b0, 1'b0, 32'h0);
        chk("refill_req", out_mem_req, 1);
        chk("refill_addr", out_mem_addr, 32'h210);
        repeat (2) step(1'b0, 1'b0, 32'h0);
        chk("drain_count", n_ena - n0, 4);
        base = dec_log.size() - 4;
        for (int i = 0; i < 4; i++) chk("drain_pc", dec_log[base + i].pc, 32'h200 + 32'(i * 4));

        // flush while waiting; stale response arrives three cycles later
        lat_cfg = 3;
        ready   = 1'b0;
        for (int k = 0; k < 10 && !ready; k++) begin
            if (out_mem_req && !p_pend) ready = 1'b1;
            else step(1'b0, 1'b0, 32'h0);
        end
        chk("stale_setup", 32'(ready), 1);
        step(1'b0, 1'b1, 32'h100);
        n0 = n_ena;
        for (int k = 0; k < 3; k++) begin
            chk("discard_req", out_mem_req, 0);
            step(1'b0, 1'b0, 32'h0);
        end
        chk("after_drop_req", out_mem_req, 0);
        step(1'b0, 1'b0, 32'h0);
        chk("restart_req", out_mem_req, 1);
        chk("restart_addr", out_mem_addr, 32'h100);
        chk("stale_not_pushed", n_ena - n0, 0);

        // randomized traffic
        lat_rand = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            step($urandom_range(0, 9) < 3, $urandom_range(0, 49) == 0,
                 $urandom & 32'hFFFF_FFFC);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end stage that fetches 32-bit instructions from the memory controller, makes a static branch prediction, and buffers fetched instructions in a small in-order queue. It feeds the decode stage one instruction per cycle: instruction word, its PC, and the predicted-taken bit. Downstream back-pressure (ROB/RS/LSqueue full) arrives through `in_stall`, and ROB misprediction recovery arrives through `in_flush`.

## Interface
- `QUEUE_DEPTH`, 4: instruction queue entries; power of two, at least 2.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_stall`  in  1  decode/ROB/RS cannot accept an instruction this cycle.
- `in_flush`  in  1  misprediction recovery from the ROB; highest priority.
- `in_flush_pc`  in  32  restart address, valid with `in_flush`.
- `out_mem_req`  out  1  fetch request to the memory controller.
- `out_mem_addr`  out  32  word address of the request.
- `in_mem_valid`  in  1  one-cycle pulse: `in_mem_inst` holds the word for the outstanding request.
- `in_mem_inst`  in  32  fetched instruction word.
- `out_decode_ena`  out  1  head entry handed to decode this cycle; the entry is popped at the clock edge.
- `out_inst`  out  32  head instruction.
- `out_pc`  out  32  head PC.
- `out_predicted_taken`  out  1  head prediction.

## Operation
- State: `fetch_pc` (32), `state` in {IDLE, WAIT, DISCARD}, circular queue with `head`/`tail` pointers and a `count` of log2(DEPTH)+1 bits.
- Outstanding requests: at most one at a time. A request is issued only when `count < QUEUE_DEPTH`, so a response can always be pushed.
- IDLE: if there is room, move to WAIT with `out_mem_req=1` and `out_mem_addr=fetch_pc`.
- WAIT:
  - `out_mem_req` and `out_mem_addr` stay stable until `in_mem_valid`.
  - On `in_mem_valid`, push {`in_mem_inst`, `fetch_pc`, pred}.
  - Set `fetch_pc` to next_pc.
  - If room remains after this edge's push and pop, stay in WAIT and request next_pc. Otherwise go to IDLE with `out_mem_req=0`.
- Prediction on the returned word:
  - opcode 1101111 (JAL): pred=1, next_pc = pc + J_IMM.
  - opcode 1100011 (branch): see Configuration.
  - All other opcodes, including JALR: pred=0, next_pc = pc+4.
  - J_IMM and B_IMM are sign-extended RISC-V immediates. Additions are 32-bit and wrap modulo 2^32.
- Decode side:
  - `out_decode_ena = (count != 0) && !in_stall && !in_flush`.
  - `out_inst`, `out_pc` and `out_predicted_taken` always show the head entry. When the queue is empty they hold the last head value (0 after reset).
  - A pop and a push on the same edge leave `count` unchanged.
- Flush:
  - Empties the queue (head=tail, count=0) and sets `fetch_pc = in_flush_pc`.
  - `out_decode_ena` is 0 during the flush cycle.
  - From WAIT with no `in_mem_valid` that cycle: go to DISCARD with `out_mem_req=0`.
  - From WAIT with `in_mem_valid` the same cycle: drop the word and go to IDLE.
  - From IDLE: stay in IDLE.
- DISCARD:
  - On `in_mem_valid`, drop the word and go to IDLE.
  - A further flush while in DISCARD updates `fetch_pc` and stays in DISCARD.
- Reset: `fetch_pc=0`, queue empty, state IDLE, `out_mem_req=0`, `out_mem_addr=0`, `out_decode_ena=0`, `out_inst=0`, `out_pc=0`, `out_predicted_taken=0`.

## Timing
- First request: `out_mem_req=1` with addr 0 after the first rising edge following reset release.
- Fetch-to-decode latency: the word pushed at edge N is visible at the head, with `out_decode_ena=1` if unstalled, during cycle N+1.
- Throughput: one instruction per memory response. Back-to-back requests are possible with no bubble.
- `in_stall` acts combinationally on `out_decode_ena` in the same cycle.
- `in_flush` takes effect at the next edge. The first request to `in_flush_pc` is issued:
  - from IDLE, the edge after the flush edge;
  - from DISCARD, the edge after the stale response is dropped.
- Full queue: `out_mem_req` drops at the edge where `count` reaches `QUEUE_DEPTH`. It is reasserted at the edge after the first pop.

## Configuration
- `FETCH_BTFN_PREDICT_EN` defined: conditional branches with negative B_IMM (inst[31]=1) get pred=1 and next_pc = pc + B_IMM. Forward branches get pred=0 and next_pc = pc+4.
- Not defined: all conditional branches get pred=0 and next_pc = pc+4. JAL is predicted taken in both builds.

## Test plan
- Reset, then memory returns ADDI words at 0, 4, 8 with 1-cycle latency → requests to 0x0, 0x4, 0x8 in order; decode sees pc 0, 4, 8, each with pred=0.
- JAL at 0x10 with offset +0x20 → entry pred=1; next request at 0x30.
- BEQ at 0x40 with offset −8 → with macro: pred=1, next request 0x38; without macro: pred=0, next request 0x44.
- `in_stall` held with 4 responses returned → `out_mem_req`=0 after the 4th push and `count`=4. Release the stall → 4 consecutive `out_decode_ena` cycles; a new request is issued the edge after the first pop.
- Flush to 0x100 while in WAIT, with the stale response arriving 3 cycles later → the stale word is never pushed; the next request is to 0x100. Repeat with the flush coinciding with `in_mem_valid` → word dropped, request to 0x100 on the next edge.
